// File: rtl/frame_dispatch.sv
// frame_dispatch: egress-side receiver of the internal frame stream.
// Parses the 2-byte header {len[11:8], portmap}, {len[7:0]}, replicates the
// payload bytes into the per-port data queues, then commits one pointer word
// to every destination port's pointer queue.
//
// Ports:
//   clk, rstn            core clock, asynchronous active-low reset
//   sof, dv, data        incoming frame stream (sof qualified by dv)
//   q_afull[3:0]         data queue i cannot take another full frame
//   ptr_full[3:0]        pointer queue i is full
//   bp0..bp3             registered backpressure per port
//   q_wr[3:0], q_din     data queue write strobes / shared write data
//   ptr_wr[3:0], ptr_din pointer queue write strobes / {0, portmap, count}
//   len_err              pulse: frame shorter than its header length
//   proto_err            pulse: sof outside IDLE or dv lost inside header
//   drop                 pulse: frame had no deliverable destination
`timescale 1ns/1ps
module frame_dispatch #(
    parameter int MAXLEN = 2047,
    parameter int NPORT  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sof,
    input  logic             dv,
    input  logic [7:0]       data,
    input  logic [NPORT-1:0] q_afull,
    input  logic [NPORT-1:0] ptr_full,
    output logic             bp0,
    output logic             bp1,
    output logic             bp2,
    output logic             bp3,
    output logic [NPORT-1:0] q_wr,
    output logic [7:0]       q_din,
    output logic [NPORT-1:0] ptr_wr,
    output logic [15:0]      ptr_din,
    output logic             len_err,
    output logic             proto_err,
    output logic             drop
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HDR1   = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]       r_state;
    logic [NPORT-1:0] r_pmap;
    logic [NPORT-1:0] r_mask;
    logic [11:0]      r_len;
    logic [10:0]      r_cnt;

    logic [NPORT-1:0] w_bp;
    logic             w_short;
    logic             w_take;
    logic             w_end;
    logic             w_commit;
    logic             w_perr;

    assign w_bp     = {bp3, bp2, bp1, bp0};
    assign w_short  = {1'b0, r_cnt} < r_len;
    // A byte is stored only while under both the header length and the
    // counter ceiling; everything else is padding or oversize and is dropped.
    assign w_take   = r_state == S_DATA && dv && w_short && {1'b0, r_cnt} < 12'(MAXLEN);
    // The pointer is committed from the first idle cycle after the payload,
    // so the registered ptr_wr is visible during the COMMIT state.
    assign w_end    = r_state == S_DATA && !dv;
    assign w_commit = w_end && r_mask != '0;
    assign w_perr   = (r_state == S_HDR1 && !dv) || (r_state != S_IDLE && dv && sof);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {bp3, bp2, bp1, bp0} <= '0;
            q_wr      <= '0;
            q_din     <= '0;
            ptr_wr    <= '0;
            ptr_din   <= '0;
            len_err   <= 1'b0;
            proto_err <= 1'b0;
            drop      <= 1'b0;
            r_state   <= S_IDLE;
            r_pmap    <= '0;
            r_mask    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
        end else begin
            {bp3, bp2, bp1, bp0} <= q_afull | ptr_full;
            q_wr      <= w_take ? r_mask : '0;
            q_din     <= w_take ? data : '0;
            ptr_wr    <= w_commit ? r_mask : '0;
            ptr_din   <= w_commit ? {1'b0, r_pmap, r_cnt} : '0;
            len_err   <= w_commit && w_short;
            drop      <= w_end && r_mask == '0;
            proto_err <= w_perr;
            case (r_state)
                S_IDLE: begin
                    if (dv && sof) begin
                        r_pmap      <= data[3:0];
                        // Mask is frozen at sof from the bp the upstream just saw.
                        r_mask      <= data[3:0] & ~w_bp;
                        r_len[11:8] <= data[7:4];
                        r_state     <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (dv) begin
                        r_len[7:0] <= data;
                        r_cnt      <= '0;
                    end
                    r_state <= dv ? S_DATA : S_IDLE;
                end
                S_DATA: begin
                    if (w_take)
                        r_cnt <= r_cnt + 11'd1;
                    if (!dv)
                        r_state <= S_COMMIT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_dispatch.sv
// tb_frame_dispatch: table-driven frame bench with a data-queue scoreboard.
`timescale 1ns/1ps
module tb_frame_dispatch;
    localparam int MAXLEN = 2047;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sof = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  data = '0;
    logic [3:0]  q_afull = '0;
    logic [3:0]  ptr_full = '0;
    logic        bp0, bp1, bp2, bp3;
    logic [3:0]  q_wr, ptr_wr;
    logic [7:0]  q_din;
    logic [15:0] ptr_din;
    logic        len_err, proto_err, drop;

    frame_dispatch dut (
        .clk(clk), .rstn(rstn), .sof(sof), .dv(dv), .data(data),
        .q_afull(q_afull), .ptr_full(ptr_full),
        .bp0(bp0), .bp1(bp1), .bp2(bp2), .bp3(bp3),
        .q_wr(q_wr), .q_din(q_din), .ptr_wr(ptr_wr), .ptr_din(ptr_din),
        .len_err(len_err), .proto_err(proto_err), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pmap;
        logic [11:0] len;
        int          nbytes;
        logic [3:0]  afull;
        logic [3:0]  pfull;
        int          sof_at;
        logic [3:0]  exp_mask;
        logic [15:0] exp_ptr;
        logic        exp_lerr;
        logic        exp_drop;
        int          exp_proto;
    } vec_t;

    vec_t        vecs[9];
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    int          n_ptr, n_proto, n_lerr, n_drop;
    int          checks, failures;

    always @(negedge clk) begin
        if (q_wr != 4'h0) obs_q.push_back({q_wr, q_din});
        if (ptr_wr != 4'h0) n_ptr <= n_ptr + 1;
        if (proto_err) n_proto <= n_proto + 1;
        if (len_err) n_lerr <= n_lerr + 1;
        if (drop) n_drop <= n_drop + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".strobes"}, 32'({bp3, bp2, bp1, bp0, q_wr, ptr_wr, len_err, proto_err, drop}), 32'h0);
        chk({nm, ".data"}, 32'({q_din, ptr_din}), 32'h0);
    endtask

    task automatic drain(input string nm);
        logic [11:0] o, e;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, ".q_write"}, 32'(o), 32'(e));
        end
        chk({nm, ".q_writes_missing"}, 32'(exp_q.size()), 32'h0);
        chk({nm, ".q_writes_extra"}, 32'(obs_q.size()), 32'h0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic send(input vec_t v, input string nm);
        int wr_n, b_ptr, b_proto, b_lerr, b_drop;
        wr_n = v.nbytes;
        if (int'(v.len) < wr_n) wr_n = int'(v.len);
        if (MAXLEN < wr_n) wr_n = MAXLEN;
        q_afull = v.afull;
        ptr_full = v.pfull;
        tick;
        tick;
        chk({nm, ".bp"}, 32'({bp3, bp2, bp1, bp0}), 32'(v.afull | v.pfull));
        b_ptr = n_ptr;
        b_proto = n_proto;
        b_lerr = n_lerr;
        b_drop = n_drop;
        dv = 1'b1;
        sof = 1'b1;
        data = {v.len[11:8], v.pmap};
        tick;
        sof = 1'b0;
        data = v.len[7:0];
        tick;
        for (int k = 0; k < v.nbytes; k++) begin
            data = 8'($urandom);
            sof = (k == v.sof_at);
            if (k == 10) begin
                q_afull = '0;
                ptr_full = '0;
            end
            if (k < wr_n && v.exp_mask != 4'h0) exp_q.push_back({v.exp_mask, data});
            tick;
        end
        dv = 1'b0;
        sof = 1'b0;
        data = '0;
        q_afull = '0;
        ptr_full = '0;
        @(negedge clk);
        @(negedge clk);
        chk({nm, ".ptr_wr"}, 32'(ptr_wr), 32'(v.exp_drop ? 4'h0 : v.exp_mask));
        if (!v.exp_drop) chk({nm, ".ptr_din"}, 32'(ptr_din), 32'(v.exp_ptr));
        chk({nm, ".len_err"}, 32'(len_err), 32'(v.exp_lerr));
        chk({nm, ".drop"}, 32'(drop), 32'(v.exp_drop));
        tick;
        tick;
        tick;
        drain(nm);
        chk({nm, ".ptr_count"}, 32'(n_ptr - b_ptr), v.exp_drop ? 32'd0 : 32'd1);
        chk({nm, ".proto_count"}, 32'(n_proto - b_proto), 32'(v.exp_proto));
        chk({nm, ".lerr_count"}, 32'(n_lerr - b_lerr), 32'(v.exp_lerr));
        chk({nm, ".drop_count"}, 32'(n_drop - b_drop), 32'(v.exp_drop));
    endtask

    initial begin
        vec_t v;
        int b_ptr, b_proto;
        vecs[0] = '{4'h2, 12'h240, 576,  4'h0, 4'h0, -1, 4'h2, 16'h1240, 1'b0, 1'b0, 0};
        vecs[1] = '{4'hF, 12'd60,  60,   4'h4, 4'h0, -1, 4'hB, 16'h783C, 1'b0, 1'b0, 0};
        vecs[2] = '{4'h8, 12'd60,  64,   4'h0, 4'h0, -1, 4'h8, 16'h403C, 1'b0, 1'b0, 0};
        vecs[3] = '{4'h1, 12'd100, 40,   4'h0, 4'h0, -1, 4'h1, 16'h0828, 1'b1, 1'b0, 0};
        vecs[4] = '{4'h1, 12'd60,  60,   4'h0, 4'h1, -1, 4'h0, 16'h0000, 1'b0, 1'b1, 0};
        vecs[5] = '{4'h4, 12'd0,   5,    4'h0, 4'h0, -1, 4'h4, 16'h2000, 1'b0, 1'b0, 0};
        vecs[6] = '{4'h1, 12'd10,  10,   4'h0, 4'h0, 5,  4'h1, 16'h080A, 1'b0, 1'b0, 1};
        vecs[7] = '{4'h1, 12'hFFF, 2100, 4'h0, 4'h0, -1, 4'h1, 16'h0FFF, 1'b1, 1'b0, 0};
        vecs[8] = '{4'h3, 12'd30,  30,   4'h1, 4'h0, -1, 4'h2, 16'h181E, 1'b0, 1'b0, 0};

        q_afull = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        q_afull = '0;
        rstn = 1'b1;
        tick;

        foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));

        b_ptr = n_ptr;
        b_proto = n_proto;
        dv = 1'b1;
        sof = 1'b1;
        data = 8'h31;
        tick;
        dv = 1'b0;
        sof = 1'b0;
        data = '0;
        tick;
        tick;
        tick;
        chk("hdr1_abort.proto_count", 32'(n_proto - b_proto), 32'd1);
        chk("hdr1_abort.ptr_count", 32'(n_ptr - b_ptr), 32'd0);
        drain("hdr1_abort");
        v = '{4'h2, 12'd20, 20, 4'h0, 4'h0, -1, 4'h2, 16'h1014, 1'b0, 1'b0, 0};
        send(v, "after_abort");

        b_ptr = n_ptr;
        dv = 1'b1;
        sof = 1'b1;
        data = 8'h01;
        tick;
        sof = 1'b0;
        data = 8'd200;
        tick;
        for (int k = 0; k < 20; k++) begin
            data = 8'($urandom);
            exp_q.push_back({4'h1, data});
            tick;
        end
        @(negedge clk);
        #1;
        rstn = 1'b0;
        dv = 1'b0;
        data = '0;
        q_afull = 4'hF;
        #2;
        chk_zero("mid_reset");
        tick;
        tick;
        chk_zero("mid_reset_held");
        q_afull = '0;
        rstn = 1'b1;
        tick;
        tick;
        drain("rst_partial");
        chk("rst_partial.ptr_count", 32'(n_ptr - b_ptr), 32'd0);
        v = '{4'h1, 12'd64, 64, 4'h0, 4'h0, -1, 4'h1, 16'h0840, 1'b0, 1'b0, 0};
        send(v, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
